// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order circular FIFO of decoded ALU1 operations.
// Dispatch pushes {insn, inp1, inp2, dst} with load. Issue/select pops the
// oldest entry with issue. The head entry is presented combinationally from
// registered state. No load/issue input reaches any output combinationally.
module alu_issue_queue #(
   parameter int NUM_ENTRIES = 4,
   parameter int ENTRY_WIDTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       issue,
   input  logic [3:0] insn,
   input  logic [4:0] inp1,
   input  logic [4:0] inp2,
   input  logic [4:0] dst,
   output logic       issue_ready,
   output logic       is_full,
   output logic [3:0] insn_out,
   output logic [4:0] inp1_out,
   output logic [4:0] inp2_out,
   output logic [4:0] dst_out
);

   // Handshake semantics:
   //   push side: an entry is taken on a rising edge when load=1 and either
   //     is_full=0 or issue=1 (a pop frees the head slot in the same cycle).
   //     A load while full without issue is dropped and leaves all state unchanged.
   //   pop side: the head entry is consumed on a rising edge when issue=1 and
   //     issue_ready=1. An issue while empty is ignored. While issue_ready=1 the
   //     head outputs hold the oldest entry. Otherwise they read as zero.

   localparam int DATA_W = 19;  // {insn[3:0], inp1[4:0], inp2[4:0], dst[4:0]}
   localparam logic [ENTRY_WIDTH:0] FULL_COUNT = (ENTRY_WIDTH + 1)'(NUM_ENTRIES);

   logic [DATA_W-1:0]      slots [NUM_ENTRIES];
   logic [ENTRY_WIDTH-1:0] head;
   logic [ENTRY_WIDTH-1:0] tail;
   logic [ENTRY_WIDTH:0]   count;
   logic [ENTRY_WIDTH:0]   count_next;
   logic                   push;
   logic                   pop;
   logic [DATA_W-1:0]      entry_in;
   logic [DATA_W-1:0]      head_word;

   assign issue_ready = (count != '0);
   assign is_full     = (count == FULL_COUNT);

   // When full, a simultaneous pop lets the push write the slot being vacated.
   // The head value leaves via the outputs before the edge overwrites it.
   assign push = load && (!is_full || issue);
   assign pop  = issue && issue_ready;

   assign entry_in = {insn, inp1, inp2, dst};

   // Occupancy update: count + push - pop
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + (ENTRY_WIDTH + 1)'(1);
         2'b01:   count_next = count - (ENTRY_WIDTH + 1)'(1);
         default: count_next = count;
      endcase
   end

   // Storage, pointers and count. Reset discards every queued entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            slots[i] <= '0;
         end
      end else begin
         if (push) begin
            slots[tail] <= entry_in;
            tail        <= tail + ENTRY_WIDTH'(1);
         end
         if (pop) begin
            head <= head + ENTRY_WIDTH'(1);
         end
         count <= count_next;
      end
   end

   // Head presentation. All zero when the queue is empty.
   always_comb begin
      head_word = '0;
      if (issue_ready) begin
         head_word = slots[head];
      end
   end

   assign insn_out = head_word[18:15];
   assign inp1_out = head_word[14:10];
   assign inp2_out = head_word[9:5];
   assign dst_out  = head_word[4:0];

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed bench with a scoreboard of expected head entries.
module tb_alu_issue_queue;

   localparam logic [3:0] F_ADD = 4'd0;
   localparam logic [3:0] F_SUB = 4'd1;
   localparam logic [3:0] F_AND = 4'd2;
   localparam logic [3:0] F_OR  = 4'd3;
   localparam logic [3:0] F_XOR = 4'd4;
   localparam logic [3:0] F_SLL = 4'd5;
   localparam logic [3:0] F_SRL = 4'd6;

   logic       clk;
   logic       reset;
   logic       load;
   logic       issue;
   logic [3:0] insn;
   logic [4:0] inp1;
   logic [4:0] inp2;
   logic [4:0] dst;
   logic       issue_ready;
   logic       is_full;
   logic [3:0] insn_out;
   logic [4:0] inp1_out;
   logic [4:0] inp2_out;
   logic [4:0] dst_out;

   logic [18:0] exp_q[$];
   int n_checks;
   int n_fail;

   alu_issue_queue #(.NUM_ENTRIES(4), .ENTRY_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .load(load), .issue(issue),
      .insn(insn), .inp1(inp1), .inp2(inp2), .dst(dst),
      .issue_ready(issue_ready), .is_full(is_full),
      .insn_out(insn_out), .inp1_out(inp1_out),
      .inp2_out(inp2_out), .dst_out(dst_out)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] ent(input logic [3:0] f, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
      return {f, a, b, d};
   endfunction

   function automatic logic [18:0] head_now();
      return {insn_out, inp1_out, inp2_out, dst_out};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Driver: inputs change at negedge+1, are sampled on the next rising edge,
   // then released at posedge+1, leaving the registered result visible.
   // accepted: whether the hand-analysed queue takes this load.
   task automatic op(input logic ld, input logic is, input logic [18:0] e,
                     input logic accepted);
      @(negedge clk);
      #1;
      load  = ld;
      issue = is;
      {insn, inp1, inp2, dst} = e;
      if (ld && accepted) exp_q.push_back(e);
      @(posedge clk);
      #1;
      load  = 1'b0;
      issue = 1'b0;
      {insn, inp1, inp2, dst} = '0;
   endtask

   // Monitor: samples mid-low-phase, when the next edge's inputs and the
   // current head are both stable. Each accepted pop is compared with the
   // oldest expected entry. An empty queue must present zeros.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            if (issue && issue_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL pop_order: got 0x%0h expected no entry at %0t", head_now(), $time);
               end else begin
                  chk("pop_order", 32'(head_now()), 32'(exp_q.pop_front()));
               end
            end else if (!issue_ready) begin
               chk("empty_head_zero", 32'(head_now()), 32'd0);
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0;
      load  = 1'b0;
      issue = 1'b0;
      {insn, inp1, inp2, dst} = '0;

      // reset state
      #2;
      chk("rst_ready", 32'(issue_ready), 32'd0);
      chk("rst_full",  32'(is_full),     32'd0);
      chk("rst_head",  32'(head_now()),  32'd0);
      @(negedge clk);
      reset = 1'b1;

      // fill on four consecutive cycles
      op(1'b1, 1'b0, ent(F_ADD, 5'd1, 5'd2, 5'd3), 1'b1);
      chk("first_ready", 32'(issue_ready), 32'd1);
      chk("first_head",  32'(head_now()),  32'(ent(F_ADD, 5'd1, 5'd2, 5'd3)));
      chk("first_full",  32'(is_full),     32'd0);
      op(1'b1, 1'b0, ent(F_SUB, 5'd4, 5'd5, 5'd6), 1'b1);
      op(1'b1, 1'b0, ent(F_AND, 5'd8, 5'd9, 5'd10), 1'b1);
      chk("three_full", 32'(is_full), 32'd0);
      op(1'b1, 1'b0, ent(F_OR, 5'd16, 5'd17, 5'd18), 1'b1);
      chk("four_full", 32'(is_full), 32'd1);

      // load while full is dropped
      op(1'b1, 1'b0, ent(F_SLL, 5'd28, 5'd0, 5'd30), 1'b0);
      chk("drop_full", 32'(is_full),    32'd1);
      chk("drop_head", 32'(head_now()), 32'(ent(F_ADD, 5'd1, 5'd2, 5'd3)));

      // drain: ADD, SUB, AND, OR
      op(1'b0, 1'b1, '0, 1'b0);
      chk("pop1_full", 32'(is_full),    32'd0);
      chk("pop1_head", 32'(head_now()), 32'(ent(F_SUB, 5'd4, 5'd5, 5'd6)));
      op(1'b0, 1'b1, '0, 1'b0);
      op(1'b0, 1'b1, '0, 1'b0);
      op(1'b0, 1'b1, '0, 1'b0);
      chk("drain_ready", 32'(issue_ready), 32'd0);
      chk("drain_head",  32'(head_now()),  32'd0);

      // wrap-around from pointers at 0
      op(1'b1, 1'b0, ent(F_XOR, 5'd12, 5'd13, 5'd14), 1'b1);
      op(1'b1, 1'b0, ent(F_SRL, 5'd19, 5'd20, 5'd21), 1'b1);
      chk("wrap_head", 32'(head_now()), 32'(ent(F_XOR, 5'd12, 5'd13, 5'd14)));
      op(1'b0, 1'b1, '0, 1'b0);
      op(1'b0, 1'b1, '0, 1'b0);
      chk("wrap_empty", 32'(issue_ready), 32'd0);

      // simultaneous push and pop while full
      op(1'b1, 1'b0, ent(F_ADD, 5'd7, 5'd11, 5'd15), 1'b1);
      op(1'b1, 1'b0, ent(F_SUB, 5'd22, 5'd23, 5'd24), 1'b1);
      op(1'b1, 1'b0, ent(F_AND, 5'd25, 5'd26, 5'd27), 1'b1);
      op(1'b1, 1'b0, ent(F_OR, 5'd29, 5'd30, 5'd31), 1'b1);
      op(1'b1, 1'b1, ent(F_XOR, 5'd2, 5'd4, 5'd8), 1'b1);
      chk("pp_full_stays", 32'(is_full),    32'd1);
      chk("pp_full_head",  32'(head_now()), 32'(ent(F_SUB, 5'd22, 5'd23, 5'd24)));
      repeat (4) op(1'b0, 1'b1, '0, 1'b0);
      chk("pp_drained", 32'(issue_ready), 32'd0);

      // simultaneous push and pop while empty: only the push happens
      op(1'b1, 1'b1, ent(F_SRL, 5'd3, 5'd6, 5'd9), 1'b1);
      chk("pp_empty_ready", 32'(issue_ready), 32'd1);
      chk("pp_empty_head",  32'(head_now()),  32'(ent(F_SRL, 5'd3, 5'd6, 5'd9)));
      op(1'b1, 1'b0, ent(F_ADD, 5'd10, 5'd12, 5'd14), 1'b1);

      // asynchronous reset mid-cycle with two entries queued
      @(negedge clk);
      #3;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_ready", 32'(issue_ready), 32'd0);
      chk("arst_full",  32'(is_full),     32'd0);
      chk("arst_head",  32'(head_now()),  32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // issue after reset is ignored until a new load
      op(1'b0, 1'b1, '0, 1'b0);
      chk("post_rst_issue", 32'(issue_ready), 32'd0);
      op(1'b1, 1'b0, ent(F_OR, 5'd1, 5'd1, 5'd1), 1'b1);
      chk("post_rst_head", 32'(head_now()), 32'(ent(F_OR, 5'd1, 5'd1, 5'd1)));
      op(1'b0, 1'b1, '0, 1'b0);
      chk("final_empty", 32'(issue_ready), 32'd0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

In-order issue queue for the ALU1 functional-unit path of the Tomasulo core. It buffers decoded ALU operations (function code, two source register tags, destination tag) in a circular FIFO of `NUM_ENTRIES` slots and presents the oldest entry to the issue stage. It sits between dispatch, which drives `load`, and the ALU issue/select logic, which drives `issue`.

## Interface
Parameters:
- `NUM_ENTRIES`, default 4: queue depth; must be a power of two ≥ 2.
- `ENTRY_WIDTH`, default 2: pointer width; must equal log2(`NUM_ENTRIES`).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `load`  in  1: push request for the entry on `insn`/`inp1`/`inp2`/`dst`.
- `issue`  in  1: pop request for the head entry.
- `insn`  in  `ALU1_FUNC` (4 b, from `sys_def.svh`): ALU function code.
- `inp1`, `inp2`  in  `REG_ADDR_LEN` (5): source register tags.
- `dst`  in  `REG_ADDR_LEN`: destination register tag.
- `issue_ready`  out  1: queue non-empty; head outputs are valid.
- `is_full`  out  1: occupancy equals `NUM_ENTRIES`.
- `insn_out`  out  `ALU1_FUNC` (4 b): head function code.
- `inp1_out`, `inp2_out`, `dst_out`  out  `REG_ADDR_LEN`: head tags.

## Operation
- State:
  - `NUM_ENTRIES`-deep storage of {insn, inp1, inp2, dst}.
  - Head and tail pointers, each `ENTRY_WIDTH` bits; they wrap modulo `NUM_ENTRIES`.
  - Occupancy count, `ENTRY_WIDTH`+1 bits.
- Push is accepted when `load` && (!`is_full` || `issue`). On accept:
  - Write the inputs to slot[tail].
  - Increment tail.
- `load` while full without `issue` is silently dropped. Storage, pointers and count are unchanged.
- Pop is accepted when `issue` && `issue_ready`. On accept, increment head.
- `issue` while empty is ignored.
- Simultaneous accepted push and pop:
  - The count is unchanged and both pointers advance.
  - When full, the popped slot is the head; the written slot is the tail, which equals the head. The write lands after the head value has been issued.
  - When empty, only the push happens, because the pop is not accepted.
- Count update: count + push − pop.
- `issue_ready` = (count != 0). `is_full` = (count == `NUM_ENTRIES`). Both are derived combinationally from the registered count.
- Head outputs:
  - Combinational from slot[head] when `issue_ready`=1.
  - All zero when empty.
- Entries leave strictly in load order. There is no wakeup or operand-readiness tracking in this block.
- Reset (`reset`=0, asynchronous):
  - Count, head and tail clear to 0.
  - Storage clears to 0.
  - `issue_ready`=0, `is_full`=0, and all data outputs = 0.
  - Reset mid-operation discards every stored entry.

## Timing
- A push or pop becomes visible after the rising edge on which it is sampled. The bench samples at the following falling edge.
- Load-to-visible latency is 1 cycle. A load into an empty queue drives `issue_ready`=1 and head outputs = the loaded entry after that edge.
- An accepted `issue` advances the head outputs to the next entry after the edge.
- `is_full` asserts after the edge that accepts the `NUM_ENTRIES`-th push. It deasserts after the first accepted pop.
- There is no combinational path from `load`/`issue` to any output.
- Deasserting reset takes effect synchronously with respect to the next edge; the first push may occur on the first rising edge after release.

## Test plan
- Reset, then load ADD(1,2,3), SUB(4,5,6), AND(8,9,10) and OR(16,17,18) on 4 consecutive cycles:
  - `issue_ready`=1 after the first load, with head = ADD/1/2/3.
  - `is_full`=1 after the fourth load.
- With the queue full, load SLL(28,0,30):
  - The push is dropped and `is_full` stays 1.
  - The later pops return only ADD, SUB, AND, OR.
- Issue 4 times:
  - The head sequence is ADD, SUB, AND, OR.
  - `is_full`=0 after the first pop.
  - After the fourth pop, `issue_ready`=0 and all head outputs = 0.
- With pointers at 0 after a full wrap, load XOR(12,13,14) and SRL(19,20,21), then issue twice:
  - The heads are XOR then SRL, confirming wrap-around.
  - The queue ends empty.
- Load and issue simultaneously:
  - When full, count stays 4, the old head is issued, and the new entry appears last in order.
  - When empty, `issue_ready`=1 next cycle with the new entry.
- Pull `reset` low mid-cycle with 2 entries queued:
  - The outputs clear immediately, without waiting for `clk`.
  - After release, `issue` is ignored until a new load.
